// File: rtl/multi_lane_mac_pe_if.sv
// Operand/result bundle of one multi-lane MAC PE: upstream operands in,
// forwarded operands out, and the handshaked window result.
interface multi_lane_mac_pe_if #(
  parameter int LANES = 2,
  parameter int A_W   = 4,
  parameter int B_W   = 8,
  parameter int ACC_W = 26
);
  logic                    pulse;
  logic                    in_valid;
  logic                    in_last;
  logic [LANES*A_W-1:0]    in_a;
  logic [LANES*B_W-1:0]    in_b;
  logic [LANES*A_W-1:0]    out_a;
  logic [LANES*B_W-1:0]    out_b;
  logic                    out_valid;
  logic                    out_last;
  logic signed [ACC_W-1:0] result;
  logic                    res_valid;
  logic                    res_ready;
  logic                    res_sat;
  logic                    overrun;

  modport slave (
    input  pulse, in_valid, in_last, in_a, in_b, res_ready,
    output out_a, out_b, out_valid, out_last, result, res_valid, res_sat, overrun
  );

  modport master (
    output pulse, in_valid, in_last, in_a, in_b, res_ready,
    input  out_a, out_b, out_valid, out_last, result, res_valid, res_sat, overrun
  );
endinterface

// File: rtl/multi_lane_mac_pe.sv
// Systolic MAC PE: LANES signed products summed per pulse, accumulated over a
// last-tagged window, one result word per window on a valid/ready port.
module multi_lane_mac_pe #(
  parameter int LANES = 2,
  parameter int A_W   = 4,
  parameter int B_W   = 8,
  parameter int ACC_W = 26,
  parameter bit SAT   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  multi_lane_mac_pe_if.slave   bus,
  output logic                 dbg_state_o
);

  localparam int P_W   = A_W + B_W;
  localparam int SUM_W = P_W + $clog2(LANES);

  typedef enum logic {OUT_IDLE = 1'b0, OUT_FULL = 1'b1} out_state_e;
  out_state_e state_q, state_d;

  logic [LANES*A_W-1:0]    a_q;
  logic [LANES*B_W-1:0]    b_q;
  logic                    v0_q, l0_q;
  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic                    v1_q, l1_q;
  logic signed [ACC_W-1:0] acc_q, acc_next;
  logic signed [ACC_W:0]   acc_ext;
  logic                    wsat_q, sat_hit;
  logic signed [ACC_W-1:0] result_q, result_d;
  logic                    res_sat_q, res_sat_d;
  logic                    overrun_q, overrun_d;
  logic                    close;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(P_W'($signed(a_q[i*A_W +: A_W])) *
                             P_W'($signed(b_q[i*B_W +: B_W])));
    end
  end

  // One guard bit above ACC_W: a sign mismatch between the top two bits is an overflow.
  assign acc_ext = (ACC_W+1)'(acc_q) + (ACC_W+1)'(sum_q);

  always_comb begin
    sat_hit  = 1'b0;
    acc_next = acc_ext[ACC_W-1:0];
    if (SAT && (acc_ext[ACC_W] != acc_ext[ACC_W-1])) begin
      sat_hit  = 1'b1;
      acc_next = acc_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign close = bus.pulse & v1_q & l1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      v0_q   <= 1'b0;
      l0_q   <= 1'b0;
      sum_q  <= '0;
      v1_q   <= 1'b0;
      l1_q   <= 1'b0;
      acc_q  <= '0;
      wsat_q <= 1'b0;
    end else if (bus.pulse) begin
      a_q   <= bus.in_a;
      b_q   <= bus.in_b;
      v0_q  <= bus.in_valid;
      l0_q  <= bus.in_last;
      sum_q <= sum_d;
      v1_q  <= v0_q;
      l1_q  <= v0_q & l0_q;
      if (v1_q) begin
        if (l1_q) begin
          acc_q  <= '0;
          wsat_q <= 1'b0;
        end else begin
          acc_q  <= acc_next;
          wsat_q <= wsat_q | sat_hit;
        end
      end
    end
  end

  // Result port: res_valid=1 holds result stable until a clk edge with
  // res_ready=1 consumes it; res_ready is sampled on every clk edge, pulse or not.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    res_sat_d = res_sat_q;
    overrun_d = overrun_q;
    case (state_q)
      OUT_IDLE: begin
        if (close) begin
          state_d   = OUT_FULL;
          result_d  = acc_next;
          res_sat_d = wsat_q | sat_hit;
        end
      end
      OUT_FULL: begin
        if (close) begin
          result_d  = acc_next;
          res_sat_d = wsat_q | sat_hit;
          if (!bus.res_ready) overrun_d = 1'b1;
        end else if (bus.res_ready) begin
          state_d = OUT_IDLE;
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= OUT_IDLE;
      result_q  <= '0;
      res_sat_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      res_sat_q <= res_sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_valid = v0_q;
  assign bus.out_last  = l0_q;
  assign bus.result    = result_q;
  assign bus.res_valid = (state_q == OUT_FULL);
  assign bus.res_sat   = res_sat_q;
  assign bus.overrun   = overrun_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_multi_lane_mac_pe.sv
// Directed bench for multi_lane_mac_pe: three instances (wide SAT, narrow SAT,
// narrow wrap) see identical stimulus; each test checks the relevant ones.
module tb_multi_lane_mac_pe;

  logic clk;
  logic reset;
  logic dbg0, dbg1, dbg2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  multi_lane_mac_pe_if #(.LANES(2), .A_W(4), .B_W(8), .ACC_W(26)) if0 ();
  multi_lane_mac_pe_if #(.LANES(2), .A_W(4), .B_W(8), .ACC_W(14)) if1 ();
  multi_lane_mac_pe_if #(.LANES(2), .A_W(4), .B_W(8), .ACC_W(14)) if2 ();

  multi_lane_mac_pe #(.LANES(2), .A_W(4), .B_W(8), .ACC_W(26), .SAT(1'b1)) u0 (
    .clk(clk), .reset(reset), .bus(if0.slave), .dbg_state_o(dbg0));
  multi_lane_mac_pe #(.LANES(2), .A_W(4), .B_W(8), .ACC_W(14), .SAT(1'b1)) u1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .dbg_state_o(dbg1));
  multi_lane_mac_pe #(.LANES(2), .A_W(4), .B_W(8), .ACC_W(14), .SAT(1'b0)) u2 (
    .clk(clk), .reset(reset), .bus(if2.slave), .dbg_state_o(dbg2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a=(-8,7), b=(-128,127): 1024 + 889 = 1913 per beat
  localparam logic [7:0]  A_BIG = 8'h78;
  localparam logic [15:0] B_BIG = 16'h7F80;
  // a=(1,1), b=(2,3): 2 + 3 = 5 per beat
  localparam logic [7:0]  A_SML = 8'h11;
  localparam logic [15:0] B_SML = 16'h0302;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, if0.result, e);
  endtask

  // driver tasks: inputs change after a negedge, one clk cycle per call
  task automatic drive(input logic p, input logic v, input logic l,
                       input logic [7:0] a, input logic [15:0] b);
    if0.pulse = p; if0.in_valid = v; if0.in_last = l; if0.in_a = a; if0.in_b = b;
    if1.pulse = p; if1.in_valid = v; if1.in_last = l; if1.in_a = a; if1.in_b = b;
    if2.pulse = p; if2.in_valid = v; if2.in_last = l; if2.in_a = a; if2.in_b = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    if0.res_ready = r;
    if1.res_ready = r;
    if2.res_ready = r;
  endtask

  task automatic beat(input logic [7:0] a, input logic [15:0] b, input logic l);
    drive(1'b1, 1'b1, l, a, b);
  endtask

  task automatic bubble(input logic [7:0] a);
    drive(1'b1, 1'b0, 1'b0, a, 16'h0000);
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 16'hFFFF);
  endtask

  task automatic consume();
    set_ready(1'b1);
    idle();
    set_ready(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    set_ready(1'b0);
    if0.pulse = 0; if0.in_valid = 0; if0.in_last = 0; if0.in_a = '0; if0.in_b = '0;
    if1.pulse = 0; if1.in_valid = 0; if1.in_last = 0; if1.in_a = '0; if1.in_b = '0;
    if2.pulse = 0; if2.in_valid = 0; if2.in_last = 0; if2.in_a = '0; if2.in_b = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_a", if0.out_a, 32'd0);
    check("rst_res_valid", if0.res_valid, 32'd0);
    check("rst_overrun", if0.overrun, 32'd0);
    check("rst_result", if0.result, 32'd0);
    reset = 1'b0;

    // basic 3-beat window and latency
    beat(A_BIG, B_BIG, 1'b0);
    check("fwd_a", if0.out_a, 32'(A_BIG));
    check("fwd_b", if0.out_b, 32'(B_BIG));
    check("fwd_valid", if0.out_valid, 32'd1);
    beat(A_BIG, B_BIG, 1'b0);
    beat(A_BIG, B_BIG, 1'b1);
    exp_q.push_back(32'd5739);
    bubble(8'h00);
    check("lat_not_yet", if0.res_valid, 32'd0);
    bubble(8'h00);
    check("lat_valid", if0.res_valid, 32'd1);
    check("dbg_full", dbg0, 32'd1);
    sb_check("basic_result");
    check("basic_sat", if0.res_sat, 32'd0);
    consume();
    check("consume_on_idle", if0.res_valid, 32'd0);

    // 5 beats: wide accumulates, narrow saturates / wraps
    for (int i = 0; i < 5; i++) beat(A_BIG, B_BIG, (i == 4));
    exp_q.push_back(32'd9565);
    bubble(8'h00);
    bubble(8'h00);
    sb_check("five_wide");
    check("five_sat_result", if1.result, 32'd8191);
    check("five_sat_flag", if1.res_sat, 32'd1);
    check("five_wrap_result", if2.result, -32'sd6819);
    check("five_wrap_flag", if2.res_sat, 32'd0);
    consume();
    beat(A_BIG, B_BIG, 1'b1);
    exp_q.push_back(32'd1913);
    bubble(8'h00);
    bubble(8'h00);
    sb_check("single_wide");
    check("single_after_sat", if1.result, 32'd1913);
    check("single_sat_clear", if1.res_sat, 32'd0);
    consume();

    // bubbles and pulse gaps inside a window
    beat(A_BIG, B_BIG, 1'b0);
    bubble(8'h3C);
    check("gap_fwd_bubble_a", if0.out_a, 32'h3C);
    check("gap_fwd_bubble_v", if0.out_valid, 32'd0);
    idle();
    check("gap_hold_a", if0.out_a, 32'h3C);
    beat(A_BIG, B_BIG, 1'b0);
    idle();
    bubble(8'h00);
    beat(A_BIG, B_BIG, 1'b1);
    check("gap_fwd_last", if0.out_last, 32'd1);
    exp_q.push_back(32'd5739);
    idle();
    check("gap_idle_no_result", if0.res_valid, 32'd0);
    bubble(8'h00);
    bubble(8'h00);
    check("gap_valid", if0.res_valid, 32'd1);
    sb_check("gap_result");
    consume();

    // back-to-back windows, collision consumed on the same edge
    beat(A_BIG, B_BIG, 1'b1);
    beat(A_SML, B_SML, 1'b1);
    exp_q.push_back(32'd1913);
    bubble(8'h00);
    check("b2b_first_valid", if0.res_valid, 32'd1);
    sb_check("b2b_first");
    set_ready(1'b1);
    exp_q.push_back(32'd5);
    bubble(8'h00);
    set_ready(1'b0);
    check("b2b_rdy_valid", if0.res_valid, 32'd1);
    check("b2b_rdy_overrun", if0.overrun, 32'd0);
    sb_check("b2b_rdy_second");
    consume();

    // back-to-back windows, collision not consumed
    beat(A_BIG, B_BIG, 1'b1);
    beat(A_SML, B_SML, 1'b1);
    bubble(8'h00);
    exp_q.push_back(32'd5);
    bubble(8'h00);
    check("ovr_flag", if0.overrun, 32'd1);
    check("ovr_valid", if0.res_valid, 32'd1);
    sb_check("ovr_result");
    consume();
    check("ovr_sticky", if0.overrun, 32'd1);

    // reset mid-window
    beat(A_BIG, B_BIG, 1'b0);
    beat(A_BIG, B_BIG, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_out_a", if0.out_a, 32'd0);
    check("mid_rst_out_valid", if0.out_valid, 32'd0);
    check("mid_rst_overrun", if0.overrun, 32'd0);
    check("mid_rst_result", if0.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    beat(A_BIG, B_BIG, 1'b1);
    exp_q.push_back(32'd1913);
    bubble(8'h00);
    bubble(8'h00);
    check("post_rst_valid", if0.res_valid, 32'd1);
    sb_check("post_rst_result");
    check("post_rst_sat", if0.res_sat, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
